led_cube_anim_scheduler: RTL and testbench
==========================================

// Module: led_cube_anim_scheduler
// PURPOSE
//  Playlist sequencer in front of LED_cube_multi_frame. Holds a small playlist of entries {animation id, loop count}.
//  Drives the driver's animate_start/animate_stop/animation_sel/loop_mode and counts end-of-pass pulses.
//  Advances through the playlist, with user play/skip/stop requests. Owns sequencing; driver's internal loop_mode is held off.
// PARAMETERS
//  PL_DEPTH    16    playlist entries (power of two)
//  IDX_W       4     playlist index width, $clog2(PL_DEPTH)
//  LOOP_W      4     per-entry loop-count width
//  NUM_ANIM    5     valid animation ids 0..NUM_ANIM-1; larger ids are skipped
//  GAP_CYCLES  1000  blank cycles between entries (animate_stop region), >=1
// PORTS
//  clk            in   1       system clock
//  rst_n          in   1       asynchronous active-low reset
//  play_req       in   1       1-cycle pulse: start playlist at index 0
//  skip_req       in   1       1-cycle pulse: abandon current entry, go to next
//  stop_req       in   1       1-cycle pulse: halt, return to IDLE
//  repeat_en      in   1       1: wrap playlist forever; 0: stop after last entry
//  pl_len         in   IDX_W+1 valid entries, 0..PL_DEPTH
//  pl_we          in   1       playlist write strobe
//  pl_waddr       in   IDX_W   playlist write index
//  pl_wdata       in   3+LOOP_W {anim_id[2:0], loops[LOOP_W-1:0]}
//  anim_wrap      in   1       1-cycle pulse from driver: last frame of animation finished
//  animate_start  out  1       1-cycle start pulse to driver
//  animate_stop   out  1       stop level to driver
//  animation_sel  out  4       selected animation; bit 3 always 0
//  loop_mode      out  1       constant 0
//  cur_idx        out  IDX_W   playlist index being played
//  busy           out  1       1 in any state except IDLE
//  list_done      out  1       1-cycle pulse when non-repeating playlist completes
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; playlist contents 0; loop_cnt 0; gap_cnt 0.
//  Playlist writes are accepted in any state, take effect next cycle, and are seen on the next LOAD only.
//  States: IDLE, LOAD, START, PLAY, STOP, GAP.
//   IDLE: play_req && pl_len!=0 -> LOAD with idx=0. play_req with pl_len==0 is ignored.
//   LOAD: latch entry[idx] into animation_sel and loops. loops==0 is treated as 1. loop_cnt=0.
//         anim_id>=NUM_ANIM -> treat as finished: advance immediately, with no START or GAP.
//         Otherwise -> START.
//   START: animate_start=1 for exactly one cycle -> PLAY.
//   PLAY: anim_wrap increments loop_cnt. When loop_cnt reaches loops-1 and anim_wrap arrives -> STOP.
//         skip_req -> STOP.
//   STOP: animate_stop=1 for one cycle; gap_cnt=GAP_CYCLES-1 -> GAP.
//   GAP: animate_stop held 1; gap_cnt counts down; at 0 -> advance.
//  Advance: if idx>=pl_len-1 (compared at advance time, so mid-play pl_len shrink wraps cleanly):
//           repeat_en=1 -> idx=0, LOAD; repeat_en=0 -> list_done pulse, IDLE. Otherwise idx+1, LOAD.
//  stop_req in any non-IDLE state: animate_stop=1 one cycle, IDLE next, idx unchanged.
//  Priority in one cycle: stop_req > skip_req > anim_wrap. play_req is ignored while busy.
//  Entering IDLE from LOAD or PLAY (stop_req) drives animate_stop=1 in the exit cycle, so the driver always parks.
//  Latency: play_req -> animate_start = 2 cycles (LOAD, START).
//  Counters saturate-free: loop_cnt is LOOP_W bits, gap_cnt is $clog2(GAP_CYCLES+1) bits.
// CONFIGURATION
//  SCHED_SHUFFLE_EN defined: advance picks the next idx from a 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1).
//   LFSR seed is 16'hACE1 at reset and free-runs.
//   Picked index = lfsr[IDX_W-1:0], reduced modulo pl_len by repeated subtraction; a repeat of the same idx
//   is allowed. repeat_en is ignored (plays forever).
//  SCHED_SHUFFLE_EN undefined: sequential order as above; no LFSR logic.
// STRUCTURE
//  Package led_cube_sched_pkg: sched_state_e enum; pl_entry_t packed struct {anim_id, loops};
//  constants LFSR_SEED and LFSR_TAPS.
//  Sub-module led_cube_sched_lfsr: step/seed, 16-bit state out; instantiated only under SCHED_SHUFFLE_EN.
//  Playlist is a register array (no RAM inference needed at 16 entries).
// TESTING (GAP_CYCLES=4 in bench)
//  1. pl_len=2, entries {1,2},{3,1}, repeat_en=0, play_req -> start@+2, sel=1; 2 wraps -> stop, 4-cycle gap, sel=3;
//     1 wrap -> list_done, IDLE.
//  2. repeat_en=1, pl_len=1, entry {0,0} -> every anim_wrap triggers STOP/GAP/START, idx stays 0, loops==0 acts as 1.
//  3. skip_req and anim_wrap in same PLAY cycle, loops=3 -> single advance, loop_cnt ignored. stop_req + skip_req
//     same cycle -> IDLE.
//  4. entry {6,1} with NUM_ANIM=5 between two valid entries -> no animate_start for it, next entry loads
//     the cycle after its LOAD.
//  5. rst_n asserted mid-GAP -> outputs 0 immediately (async), IDLE. play_req with pl_len=0 -> no response.
//  6. SCHED_SHUFFLE_EN, pl_len=3, 1000 advances -> cur_idx always <3, each index hit >=200 times.

Source files
------------

// File: rtl/led_cube_sched_pkg.sv
// ---------------------------------------------------------------------------
// led_cube_sched_pkg : shared types/constants for the LED-cube playlist scheduler
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package led_cube_sched_pkg;

  localparam int          SCHED_LOOP_W = 4;
  localparam logic [15:0] LFSR_SEED    = 16'hACE1;
  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_PLAY  = 3'd3,
    S_STOP  = 3'd4,
    S_GAP   = 3'd5
  } sched_state_e;

  typedef struct packed {
    logic [2:0]              anim_id;
    logic [SCHED_LOOP_W-1:0] loops;
  } pl_entry_t;

endpackage

`default_nettype wire

// File: rtl/led_cube_sched_lfsr.sv
// ---------------------------------------------------------------------------
// led_cube_sched_lfsr : free-running 16-bit Galois LFSR used for shuffle order
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module led_cube_sched_lfsr
  import led_cube_sched_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_step,
  output logic [15:0] o_state
);

  logic [15:0] r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= LFSR_SEED;
    end else if (i_step) begin
      r_state <= {1'b0, r_state[15:1]} ^ (r_state[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  assign o_state = r_state;

endmodule

`default_nettype wire

// File: rtl/led_cube_anim_scheduler.sv
// ---------------------------------------------------------------------------
// led_cube_anim_scheduler : playlist sequencer driving LED_cube_multi_frame
// Optional macro SCHED_SHUFFLE_EN selects LFSR-shuffled playback.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module led_cube_anim_scheduler
  import led_cube_sched_pkg::*;
#(
  parameter int PL_DEPTH   = 16,
  parameter int IDX_W      = 4,
  parameter int LOOP_W     = SCHED_LOOP_W,
  parameter int NUM_ANIM   = 5,
  parameter int GAP_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_play_req,
  input  logic              i_skip_req,
  input  logic              i_stop_req,
  input  logic              i_repeat_en,
  input  logic [IDX_W:0]    i_pl_len,
  input  logic              i_pl_we,
  input  logic [IDX_W-1:0]  i_pl_waddr,
  input  logic [3+LOOP_W-1:0] i_pl_wdata,
  input  logic              i_anim_wrap,
  output logic              o_animate_start,
  output logic              o_animate_stop,
  output logic [3:0]        o_animation_sel,
  output logic              o_loop_mode,
  output logic [IDX_W-1:0]  o_cur_idx,
  output logic              o_busy,
  output logic              o_list_done
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  sched_state_e     r_state;
  pl_entry_t        r_pl [PL_DEPTH];
  logic [IDX_W-1:0] r_idx;
  logic [LOOP_W-1:0] r_loops;
  logic [LOOP_W-1:0] r_loop_cnt;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [2:0]       r_sel;
  logic             r_start;
  logic             r_stop;
  logic             r_busy;
  logic             r_done;

  pl_entry_t        w_ent;
  logic [IDX_W-1:0] w_next_idx;
  logic             w_adv_idle;

  assign w_ent = r_pl[r_idx];

`ifdef SCHED_SHUFFLE_EN
  logic [15:0]  w_lfsr;
  logic [IDX_W:0] w_pick;

  led_cube_sched_lfsr u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_step  (1'b1),
    .o_state (w_lfsr)
  );

  // Modulo by repeated subtraction; PL_DEPTH passes cover the worst case len=1
  always_comb begin
    w_pick = {1'b0, w_lfsr[IDX_W-1:0]};
    for (int i = 0; i < PL_DEPTH; i++) begin
      if (w_pick >= i_pl_len) w_pick = w_pick - i_pl_len;
    end
    w_next_idx = w_pick[IDX_W-1:0];
    w_adv_idle = (i_pl_len == '0);
  end
`else
  logic w_last;

  // Evaluated at advance time so a shrunk pl_len (even 0) ends or wraps cleanly
  assign w_last = (({1'b0, r_idx} + {{IDX_W{1'b0}}, 1'b1}) >= i_pl_len);

  always_comb begin
    w_next_idx = w_last ? '0 : r_idx + IDX_W'(1);
    w_adv_idle = w_last && !i_repeat_en;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_loops    <= '0;
      r_loop_cnt <= '0;
      r_gap_cnt  <= '0;
      r_sel      <= '0;
      r_start    <= 1'b0;
      r_stop     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      for (int i = 0; i < PL_DEPTH; i++) r_pl[i] <= '0;
    end else begin
      r_start <= 1'b0;
      r_done  <= 1'b0;
      if (i_pl_we) r_pl[i_pl_waddr] <= i_pl_wdata;

      if (r_state != S_IDLE && i_stop_req) begin
        r_state <= S_IDLE;
        r_stop  <= 1'b1;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_stop <= 1'b0;
            if (i_play_req && i_pl_len != '0) begin
              r_idx   <= '0;
              r_state <= S_LOAD;
              r_busy  <= 1'b1;
            end
          end
          S_LOAD: begin
            r_sel      <= w_ent.anim_id;
            r_loops    <= (w_ent.loops == '0) ? LOOP_W'(1) : w_ent.loops;
            r_loop_cnt <= '0;
            if (32'(w_ent.anim_id) >= NUM_ANIM) begin
              if (w_adv_idle) begin
                r_state <= S_IDLE;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_stop  <= 1'b1;
              end else begin
                r_idx   <= w_next_idx;
                r_state <= S_LOAD;
              end
            end else begin
              r_state <= S_START;
              r_start <= 1'b1;
            end
          end
          S_START: r_state <= S_PLAY;
          S_PLAY: begin
            if (i_skip_req) begin
              r_state <= S_STOP;
              r_stop  <= 1'b1;
            end else if (i_anim_wrap) begin
              if (r_loop_cnt == r_loops - LOOP_W'(1)) begin
                r_state <= S_STOP;
                r_stop  <= 1'b1;
              end else begin
                r_loop_cnt <= r_loop_cnt + LOOP_W'(1);
              end
            end
          end
          S_STOP: begin
            r_gap_cnt <= GAP_W'(GAP_CYCLES - 1);
            r_state   <= S_GAP;
          end
          S_GAP: begin
            if (r_gap_cnt == '0) begin
              if (w_adv_idle) begin
                r_state <= S_IDLE;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
              end else begin
                r_idx   <= w_next_idx;
                r_state <= S_LOAD;
                r_stop  <= 1'b0;
              end
            end else begin
              r_gap_cnt <= r_gap_cnt - GAP_W'(1);
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_animate_start = r_start;
  assign o_animate_stop  = r_stop;
  assign o_animation_sel = {1'b0, r_sel};
  assign o_loop_mode     = 1'b0;
  assign o_cur_idx       = r_idx;
  assign o_busy          = r_busy;
  assign o_list_done     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_led_cube_anim_scheduler.sv
// ---------------------------------------------------------------------------
// tb_led_cube_anim_scheduler : self-checking bench for the playlist scheduler
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_led_cube_anim_scheduler;

  localparam int GAP = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_play_req = 1'b0, i_skip_req = 1'b0, i_stop_req = 1'b0;
  logic       i_repeat_en = 1'b0, i_pl_we = 1'b0, i_anim_wrap = 1'b0;
  logic [4:0] i_pl_len = '0;
  logic [3:0] i_pl_waddr = '0;
  logic [6:0] i_pl_wdata = '0;
  logic       o_animate_start, o_animate_stop, o_loop_mode, o_busy, o_list_done;
  logic [3:0] o_animation_sel, o_cur_idx;

  int n_vec = 0;
  int n_err = 0;
  bit m_chk = 1'b1;
  bit saw_bad_start = 1'b0;

  led_cube_anim_scheduler #(.GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_play_req(i_play_req), .i_skip_req(i_skip_req), .i_stop_req(i_stop_req),
    .i_repeat_en(i_repeat_en), .i_pl_len(i_pl_len), .i_pl_we(i_pl_we),
    .i_pl_waddr(i_pl_waddr), .i_pl_wdata(i_pl_wdata), .i_anim_wrap(i_anim_wrap),
    .o_animate_start(o_animate_start), .o_animate_stop(o_animate_stop),
    .o_animation_sel(o_animation_sel), .o_loop_mode(o_loop_mode),
    .o_cur_idx(o_cur_idx), .o_busy(o_busy), .o_list_done(o_list_done)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 idle,1 load,2 start,3 play,4 stop,5 gap.
  // Tracks wraps still owed and gap cycles still owed rather than up-counters.
  int         m_ph = 0;
  logic [3:0] m_idx = '0;
  logic [2:0] m_sel = '0;
  int         m_left = 0;
  int         m_gap = 0;
  bit         m_start = 0, m_stop = 0, m_busy = 0, m_done = 0;
  int         m_id [16];
  int         m_lp [16];

  task automatic m_adv(inout int nph);
    if (int'(m_idx) + 1 >= int'(i_pl_len)) begin
      if (i_repeat_en) begin m_idx = '0; nph = 1; end
      else begin m_done = 1; nph = 0; end
    end else begin
      m_idx = m_idx + 4'd1;
      nph = 1;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph = 0; m_idx = '0; m_sel = '0; m_left = 0; m_gap = 0;
      m_start = 0; m_stop = 0; m_busy = 0; m_done = 0;
      for (int i = 0; i < 16; i++) begin m_id[i] = 0; m_lp[i] = 0; end
    end else begin
      int nph;
      nph = m_ph;
      m_done = 0;
      if (m_ph != 0 && i_stop_req) nph = 0;
      else case (m_ph)
        0: if (i_play_req && i_pl_len != 0) begin m_idx = '0; nph = 1; end
        1: begin
          m_sel  = 3'(m_id[m_idx]);
          m_left = (m_lp[m_idx] == 0) ? 1 : m_lp[m_idx];
          if (m_id[m_idx] >= 5) m_adv(nph); else nph = 2;
        end
        2: nph = 3;
        3: if (i_skip_req) nph = 4;
           else if (i_anim_wrap) begin m_left--; if (m_left == 0) nph = 4; end
        4: begin m_gap = GAP; nph = 5; end
        5: begin m_gap--; if (m_gap == 0) m_adv(nph); end
        default: nph = 0;
      endcase
      m_start = (nph == 2);
      m_stop  = (nph == 4) || (nph == 5) || (nph == 0 && m_ph != 0);
      m_busy  = (nph != 0);
      m_ph    = nph;
      if (i_pl_we) begin
        m_id[i_pl_waddr] = int'(i_pl_wdata[6:4]);
        m_lp[i_pl_waddr] = int'(i_pl_wdata[3:0]);
      end
    end
  end

  always @(negedge clk) begin
    logic [12:0] act, exp_v;
    act   = {o_animate_start, o_animate_stop, o_animation_sel, o_loop_mode, o_cur_idx, o_busy, o_list_done};
    exp_v = {m_start, m_stop, 1'b0, m_sel, 1'b0, m_idx, m_busy, m_done};
    if (o_animate_start === 1'b1 && o_animation_sel == 4'd6) saw_bad_start = 1'b1;
    if (m_chk) begin
      n_vec++;
      if (act !== exp_v) begin
        n_err++;
        $display("FAIL model_cmp t=%0t got start/stop/sel/lm/idx/busy/done=%b required %b", $time, act, exp_v);
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int id, input int lp);
    i_pl_we = 1'b1; i_pl_waddr = 4'(a); i_pl_wdata = {3'(id), 4'(lp)};
    tick();
    i_pl_we = 1'b0;
  endtask

  task automatic play();  i_play_req  = 1'b1; tick(); i_play_req  = 1'b0; endtask
  task automatic wrap();  i_anim_wrap = 1'b1; tick(); i_anim_wrap = 1'b0; endtask
  task automatic stopr(); i_stop_req  = 1'b1; tick(); i_stop_req  = 1'b0; endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    check("reset_busy",  32'(o_busy), 32'd0);
    check("reset_stop",  32'(o_animate_stop), 32'd0);
    check("reset_sel",   32'(o_animation_sel), 32'd0);
    rst_n = 1'b1;
    tick();

`ifdef SCHED_SHUFFLE_EN
    begin
      int hits [3];
      hits = '{0, 0, 0};
      m_chk = 1'b0;
      for (int a = 0; a < 3; a++) wr(a, 7, 1);
      i_pl_len = 5'd3;
      play();
      for (int k = 0; k < 1000; k++) begin
        tick();
        check("shuffle_idx_range", 32'(o_cur_idx < 4'd3), 32'd1);
        if (o_cur_idx < 4'd3) hits[o_cur_idx]++;
      end
      for (int a = 0; a < 3; a++) check($sformatf("shuffle_hits%0d_ge200", a), 32'(hits[a] >= 200), 32'd1);
      stopr();
    end
`else
    // 1: two-entry sequential list
    wr(0, 1, 2); wr(1, 3, 1);
    i_pl_len = 5'd2; i_repeat_en = 1'b0;
    play(); tick();
    check("t1_start_lat2", 32'(o_animate_start), 32'd1);
    check("t1_sel1",       32'(o_animation_sel), 32'd1);
    tick(); wrap(); wrap();
    check("t1_stop_after2wraps", 32'(o_animate_stop), 32'd1);
    repeat (6) tick();
    check("t1_start2", 32'(o_animate_start), 32'd1);
    check("t1_sel3",   32'(o_animation_sel), 32'd3);
    tick(); wrap();
    repeat (5) tick();
    check("t1_list_done", 32'(o_list_done), 32'd1);
    check("t1_idle",      32'(o_busy), 32'd0);
    tick();
    check("t1_done_pulse1", 32'(o_list_done), 32'd0);

    // 2: single repeating entry with loops==0
    wr(0, 0, 0);
    i_pl_len = 5'd1; i_repeat_en = 1'b1;
    play(); tick();
    check("t2_start", 32'(o_animate_start), 32'd1);
    for (int r = 0; r < 3; r++) begin
      tick(); wrap();
      check("t2_stop_each_wrap", 32'(o_animate_stop), 32'd1);
      repeat (6) tick();
      check("t2_restart", 32'(o_animate_start), 32'd1);
      check("t2_idx0",    32'(o_cur_idx), 32'd0);
    end
    stopr();
    i_repeat_en = 1'b0;

    // 3: skip+wrap together, then stop+skip together
    wr(0, 2, 3); wr(1, 4, 1);
    i_pl_len = 5'd2;
    play(); tick(); tick();
    i_skip_req = 1'b1; i_anim_wrap = 1'b1; tick(); i_skip_req = 1'b0; i_anim_wrap = 1'b0;
    check("t3_skip_stop", 32'(o_animate_stop), 32'd1);
    repeat (6) tick();
    check("t3_next_start", 32'(o_animate_start), 32'd1);
    check("t3_next_idx",   32'(o_cur_idx), 32'd1);
    check("t3_next_sel",   32'(o_animation_sel), 32'd4);
    tick();
    i_stop_req = 1'b1; i_skip_req = 1'b1; tick(); i_stop_req = 1'b0; i_skip_req = 1'b0;
    check("t3_stop_idle", 32'(o_busy), 32'd0);
    check("t3_stop_park", 32'(o_animate_stop), 32'd1);
    tick();
    check("t3_park_1cyc", 32'(o_animate_stop), 32'd0);

    // 4: invalid animation id between two valid ones
    wr(0, 1, 1); wr(1, 6, 1); wr(2, 2, 1);
    i_pl_len = 5'd3;
    play(); tick(); tick(); wrap();
    repeat (5) tick();
    check("t4_load_bad_idx", 32'(o_cur_idx), 32'd1);
    tick();
    check("t4_next_load_idx", 32'(o_cur_idx), 32'd2);
    tick();
    check("t4_start_sel2", 32'({o_animate_start, o_animation_sel}), 32'h12);
    tick(); wrap();
    repeat (5) tick();
    check("t4_done", 32'(o_list_done), 32'd1);
    check("t4_no_start_bad_id", 32'(saw_bad_start), 32'd0);

    // 5: async reset in the gap, then play with empty list
    play(); tick(); tick(); wrap(); tick();
    #3 rst_n = 1'b0;
    #1;
    check("t5_async_busy", 32'(o_busy), 32'd0);
    check("t5_async_stop", 32'(o_animate_stop), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    i_pl_len = 5'd0;
    play();
    repeat (3) tick();
    check("t5_empty_busy",  32'(o_busy), 32'd0);
    check("t5_empty_start", 32'(o_animate_start), 32'd0);
`endif

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
